receptor_ascii: RTL and testbench

- Serial receiver that collects a block of N_CARACTERES 7-bit ASCII characters from an asynchronous line and presents them as one parallel word.
- Frame format: start bit (0), 7 data bits LSB first, even-parity bit, 2 stop bits (1); line idles high.
- Built as one module with an internal control FSM, bit-timing counter, bit counter, shift register and character buffer.
- Sits at the receiving end of the board's ASCII serial link.

---
 rtl/receptor_ascii.sv | 195 +++++++++++++++++++
 tb/tb_receptor_ascii.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_ascii.sv
`default_nettype none
// ============================================================================
// Module   : receptor_ascii
// Brief    : Async serial receiver (start, 7 data LSB first, even parity,
//            2 stop) that assembles N_CARACTERES characters into one word.
//            Optional parity checking: RECEPTOR_ASCII_PARIDADE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module receptor_ascii #(
  parameter int CLKS_POR_BIT = 434,
  parameter int N_CARACTERES = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic                      entrada_serial,
  output logic [7*N_CARACTERES-1:0] dados_ascii,
  output logic                      recebendo,
  output logic                      pronto,
  output logic                      erro_quadro,
  output logic                      erro_paridade,
  output logic [3:0]                db_estado
);

  localparam int c_tw = $clog2(CLKS_POR_BIT + 1);
  localparam int c_iw = (N_CARACTERES > 1) ? $clog2(N_CARACTERES) : 1;
  localparam logic [c_tw-1:0] c_bit    = c_tw'(CLKS_POR_BIT);
  localparam logic [c_tw-1:0] c_meio   = c_tw'(CLKS_POR_BIT / 2);
  localparam logic [c_tw-1:0] c_um     = c_tw'(1);
  localparam logic [c_iw-1:0] c_ultimo = c_iw'(N_CARACTERES - 1);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    CONFIRMA = 4'd2,
    DADOS    = 4'd3,
    PARIDADE = 4'd4,
    PARADA   = 4'd5,
    ARMAZENA = 4'd6,
    FINAL    = 4'd7
  } estado_t;

  estado_t                  r_estado, w_proximo;
  logic                     r_sinc1, r_sinc2;
  logic [c_tw-1:0]          r_timer;
  logic [2:0]               r_bits;
  logic [6:0]               r_shift;
  logic [c_iw-1:0]          r_indice;
  logic [7*N_CARACTERES-1:0] r_dados;
  logic                     r_erro_quadro;
  logic                     w_linha, w_expira;

  // Synchronizer resets to the idle (high) line level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sinc1 <= 1'b1;
      r_sinc2 <= 1'b1;
    end else begin
      r_sinc1 <= entrada_serial;
      r_sinc2 <= r_sinc1;
    end
  end

  assign w_linha  = r_sinc2;
  assign w_expira = (r_timer == c_um);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_proximo;
  end

  always_comb begin
    w_proximo = r_estado;
    recebendo = 1'b0;
    pronto    = 1'b0;
    case (r_estado)
      INICIAL:  if (iniciar) w_proximo = ESPERA;
      ESPERA: begin
        recebendo = 1'b1;
        if (!w_linha) w_proximo = CONFIRMA;
      end
      CONFIRMA: begin
        recebendo = 1'b1;
        if (w_expira) w_proximo = w_linha ? ESPERA : DADOS;
      end
      DADOS: begin
        recebendo = 1'b1;
        if (w_expira && (r_bits == 3'd6)) w_proximo = PARIDADE;
      end
      PARIDADE: begin
        recebendo = 1'b1;
        if (w_expira) w_proximo = PARADA;
      end
      PARADA: begin
        recebendo = 1'b1;
        if (w_expira) w_proximo = ARMAZENA;
      end
      ARMAZENA: begin
        recebendo = 1'b1;
        w_proximo = (r_indice == c_ultimo) ? FINAL : ESPERA;
      end
      FINAL: begin
        pronto = 1'b1;
        if (iniciar) w_proximo = ESPERA;
      end
      default:  w_proximo = INICIAL;
    endcase
  end

`ifdef RECEPTOR_ASCII_PARIDADE_EN
  logic r_erro_paridade;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer       <= '0;
      r_bits        <= '0;
      r_shift       <= '0;
      r_indice      <= '0;
      r_dados       <= '0;
      r_erro_quadro <= 1'b0;
`ifdef RECEPTOR_ASCII_PARIDADE_EN
      r_erro_paridade <= 1'b0;
`endif
    end else begin
      case (r_estado)
        INICIAL, FINAL: begin
          if (iniciar) begin
            r_dados       <= '0;
            r_indice      <= '0;
            r_erro_quadro <= 1'b0;
`ifdef RECEPTOR_ASCII_PARIDADE_EN
            r_erro_paridade <= 1'b0;
`endif
          end
        end
        ESPERA: if (!w_linha) r_timer <= c_meio;
        CONFIRMA: begin
          if (w_expira) begin
            r_timer <= c_bit;
            r_bits  <= '0;
          end else begin
            r_timer <= r_timer - c_um;
          end
        end
        DADOS: begin
          if (w_expira) begin
            r_timer <= c_bit;
            r_shift <= {w_linha, r_shift[6:1]};
            r_bits  <= r_bits + 3'd1;
          end else begin
            r_timer <= r_timer - c_um;
          end
        end
        PARIDADE: begin
          if (w_expira) begin
            r_timer <= c_bit;
`ifdef RECEPTOR_ASCII_PARIDADE_EN
            if ((^r_shift) != w_linha) r_erro_paridade <= 1'b1;
`endif
          end else begin
            r_timer <= r_timer - c_um;
          end
        end
        PARADA: begin
          if (w_expira) begin
            r_timer <= c_bit;
            if (!w_linha) r_erro_quadro <= 1'b1;
          end else begin
            r_timer <= r_timer - c_um;
          end
        end
        ARMAZENA: begin
          // Characters with a bad stop bit are stored like any other
          for (int k = 0; k < N_CARACTERES; k++) begin
            if (r_indice == c_iw'(k)) r_dados[7*k +: 7] <= r_shift;
          end
          if (r_indice != c_ultimo) r_indice <= r_indice + c_iw'(1);
        end
        default: ;
      endcase
    end
  end

  assign dados_ascii = r_dados;
  assign erro_quadro = r_erro_quadro;
  assign db_estado   = r_estado;
`ifdef RECEPTOR_ASCII_PARIDADE_EN
  assign erro_paridade = r_erro_paridade;
`else
  assign erro_paridade = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_receptor_ascii.sv
`default_nettype none
// ============================================================================
// Module   : tb_receptor_ascii
// Brief    : Randomized self-checking bench for receptor_ascii against a
//            character-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receptor_ascii;

  localparam int CLKS = 4;
  localparam int N    = 8;
`ifdef RECEPTOR_ASCII_PARIDADE_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           iniciar;
  logic           entrada_serial;
  logic [7*N-1:0] dados_ascii;
  logic           recebendo, pronto, erro_quadro, erro_paridade;
  logic [3:0]     db_estado;

  int checks = 0;
  int errors = 0;

  logic [6:0] m_chars [N];
  bit         m_pbad  [N];
  bit         m_sbad  [N];

  always #5 clock = ~clock;

  receptor_ascii #(.CLKS_POR_BIT(CLKS), .N_CARACTERES(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .entrada_serial (entrada_serial),
    .dados_ascii    (dados_ascii),
    .recebendo      (recebendo),
    .pronto         (pronto),
    .erro_quadro    (erro_quadro),
    .erro_paridade  (erro_paridade),
    .db_estado      (db_estado)
  );

  // Reference model: the block is simply the characters packed in arrival order
  function automatic logic [7*N-1:0] model_dados();
    logic [7*N-1:0] acc = '0;
    for (int k = 0; k < N; k++)
      acc = acc | ({{(7*N-7){1'b0}}, m_chars[k]} << (7*k));
    return acc;
  endfunction

  function automatic bit model_eq();
    bit any = 1'b0;
    for (int k = 0; k < N; k++) any = any | m_sbad[k];
    return any;
  endfunction

  function automatic bit model_ep();
    bit any = 1'b0;
    for (int k = 0; k < N; k++) any = any | m_pbad[k];
    return PAR_EN & any;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      m_chars[k] = 7'($urandom_range(127, 0));
      m_pbad[k]  = 1'b0;
      m_sbad[k]  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [6:0] ch, input bit pbad, input bit sbad);
    logic [10:0] f;
    f = {1'b1, ~sbad, (^ch) ^ pbad, ch, 1'b0};
    for (int i = 0; i < 11; i++) begin
      entrada_serial = f[i];
      tick(CLKS);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max);
    for (int k = lo; k <= hi; k++) begin
      send_frame(m_chars[k], m_pbad[k], m_sbad[k]);
      tick(int'($urandom_range(gap_max, 0)) + (m_sbad[k] ? 4 : 0));
    end
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
  endtask

  task automatic wait_pronto(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (pronto === 1'b1) ok = 1'b1;
      else tick(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_pronto_timeout got pronto=%b exp 1", tag, pronto);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; entrada_serial = 1'b1;
    tick(3);
    checks++; if (dados_ascii !== '0) begin errors++; $display("FAIL reset_dados got %h exp 0", dados_ascii); end
    checks++; if ({recebendo, pronto, erro_quadro, erro_paridade} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {recebendo, pronto, erro_quadro, erro_paridade}); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got %0d exp 0", db_estado); end
    reset = 1'b0;
    tick(3);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_estado got %0d exp 0", db_estado); end
  endtask

  task automatic test_abc();
    for (int k = 0; k < N; k++) begin
      m_chars[k] = 7'(8'h41 + k); m_pbad[k] = 1'b0; m_sbad[k] = 1'b0;
    end
    pulse_iniciar();
    tick(1);
    checks++; if (recebendo !== 1'b1) begin errors++; $display("FAIL abc_recebendo_armed got %b exp 1", recebendo); end
    send_range(0, N-1, 0);
    wait_pronto("abc");
    checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL abc_dados got %h exp %h", dados_ascii, model_dados()); end
    checks++; if (dados_ascii[6:0] !== 7'h41) begin errors++; $display("FAIL abc_first got %h exp 41", dados_ascii[6:0]); end
    checks++; if (dados_ascii[55:49] !== 7'h48) begin errors++; $display("FAIL abc_last got %h exp 48", dados_ascii[55:49]); end
    checks++; if ({recebendo, erro_quadro, erro_paridade} !== 3'b000) begin
      errors++; $display("FAIL abc_flags got %b exp 000", {recebendo, erro_quadro, erro_paridade}); end
    checks++; if (db_estado !== 4'd7) begin errors++; $display("FAIL abc_estado got %0d exp 7", db_estado); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      pulse_iniciar();
      send_range(0, N-1, 5);
      wait_pronto("rand");
      checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL rand%0d_dados got %h exp %h", r, dados_ascii, model_dados()); end
      checks++; if ({erro_quadro, erro_paridade} !== {model_eq(), model_ep()}) begin
        errors++; $display("FAIL rand%0d_errs got %b exp %b", r, {erro_quadro, erro_paridade}, {model_eq(), model_ep()}); end
    end
  endtask

  task automatic test_glitch();
    bit seen_confirma = 1'b0;
    fill_random();
    pulse_iniciar();
    tick(3);
    entrada_serial = 1'b0;
    tick(1);
    entrada_serial = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (db_estado === 4'd2) seen_confirma = 1'b1;
      tick(1);
    end
    checks++; if (seen_confirma !== 1'b1) begin errors++; $display("FAIL glitch_confirma got 0 exp 1"); end
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL glitch_estado got %0d exp 1", db_estado); end
    checks++; if (dados_ascii !== '0) begin errors++; $display("FAIL glitch_nostore got %h exp 0", dados_ascii); end
    send_range(0, N-1, 2);
    wait_pronto("glitch");
    checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL glitch_dados got %h exp %h", dados_ascii, model_dados()); end
  endtask

  task automatic test_paridade();
    fill_random();
    m_chars[3] = 7'h43;
    m_pbad[3]  = 1'b1;
    pulse_iniciar();
    send_range(0, N-1, 3);
    wait_pronto("par");
    checks++; if (erro_paridade !== model_ep()) begin errors++; $display("FAIL par_flag got %b exp %b", erro_paridade, model_ep()); end
    checks++; if (dados_ascii[27:21] !== 7'h43) begin errors++; $display("FAIL par_slot got %h exp 43", dados_ascii[27:21]); end
    checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL par_dados got %h exp %h", dados_ascii, model_dados()); end
    tick(20);
    checks++; if (erro_paridade !== model_ep()) begin errors++; $display("FAIL par_sticky got %b exp %b", erro_paridade, model_ep()); end
    fill_random();
    pulse_iniciar();
    checks++; if (erro_paridade !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", erro_paridade); end
    send_range(0, N-1, 1);
    wait_pronto("par2");
  endtask

  task automatic test_quadro();
    fill_random();
    m_chars[5] = 7'h5A;
    m_sbad[5]  = 1'b1;
    pulse_iniciar();
    send_range(0, N-1, 2);
    wait_pronto("quadro");
    checks++; if (erro_quadro !== 1'b1) begin errors++; $display("FAIL quadro_flag got %b exp 1", erro_quadro); end
    checks++; if (dados_ascii[41:35] !== 7'h5A) begin errors++; $display("FAIL quadro_slot got %h exp 5a", dados_ascii[41:35]); end
    checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL quadro_dados got %h exp %h", dados_ascii, model_dados()); end
    checks++; if (erro_paridade !== model_ep()) begin errors++; $display("FAIL quadro_par got %b exp %b", erro_paridade, model_ep()); end
  endtask

  task automatic test_back_to_back();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    checks++; if (dados_ascii !== '0) begin errors++; $display("FAIL restart_dados got %h exp 0", dados_ascii); end
    checks++; if ({pronto, recebendo, erro_quadro} !== 3'b010) begin
      errors++; $display("FAIL restart_flags got %b exp 010", {pronto, recebendo, erro_quadro}); end
    fill_random();
    send_range(0, 3, 1);
    pulse_iniciar();
    checks++; if (recebendo !== 1'b1) begin errors++; $display("FAIL ignore_iniciar_recebendo got %b exp 1", recebendo); end
    send_range(4, N-1, 1);
    wait_pronto("b2b");
    checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL b2b_dados got %h exp %h", dados_ascii, model_dados()); end
  endtask

  task automatic test_reset_mid();
    fill_random();
    pulse_iniciar();
    send_range(0, 1, 0);
    entrada_serial = 1'b0;         tick(CLKS);
    entrada_serial = m_chars[2][0]; tick(CLKS);
    entrada_serial = m_chars[2][1]; tick(CLKS/2);
    checks++; if (db_estado !== 4'd3) begin errors++; $display("FAIL mid_pre_estado got %0d exp 3", db_estado); end
    #2 reset = 1'b1;
    #1;
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL mid_async_estado got %0d exp 0", db_estado); end
    checks++; if ({dados_ascii, recebendo, pronto, erro_quadro, erro_paridade} !== '0) begin
      errors++; $display("FAIL mid_async_outputs got %h exp 0", {dados_ascii, recebendo, pronto, erro_quadro, erro_paridade}); end
    entrada_serial = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    fill_random();
    pulse_iniciar();
    send_range(0, N-1, 3);
    wait_pronto("mid");
    checks++; if (dados_ascii !== model_dados()) begin errors++; $display("FAIL mid_dados got %h exp %h", dados_ascii, model_dados()); end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; entrada_serial = 1'b1;
    @(negedge clock);
    test_reset();
    test_abc();
    test_random();
    test_glitch();
    test_paridade();
    test_quadro();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
